// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_pkg
// Description : Shared 640x480@60 timing constants, colour constants and the
//               sync-decoder lock state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    // Horizontal timing, in pixel clocks
    localparam int H_SYNC  = 96;
    localparam int H_BACK  = 48;
    localparam int H_DISP  = 640;
    localparam int H_TOTAL = 800;

    // Vertical timing, in lines
    localparam int V_SYNC  = 2;
    localparam int V_BACK  = 33;
    localparam int V_DISP  = 480;
    localparam int V_TOTAL = 525;

    // Datapath widths
    localparam int RGB_W     = 12;
    localparam int CNT_W     = 10;
    localparam int ERR_CNT_W = 8;

    // 4:4:4 colour constants {R,G,B}
    localparam logic [RGB_W-1:0] COLOR_BLACK = 12'h000;
    localparam logic [RGB_W-1:0] COLOR_WHITE = 12'hFFF;
    localparam logic [RGB_W-1:0] COLOR_RED   = 12'hF00;
    localparam logic [RGB_W-1:0] COLOR_GREEN = 12'h0F0;
    localparam logic [RGB_W-1:0] COLOR_BLUE  = 12'h00F;

    // Lock state of the sync decoder
    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } sync_state_t;

endpackage : vga_timing_pkg
`default_nettype wire

// File: rtl/vga_sync_sampler.sv
`default_nettype none
// ============================================================================
// Module      : vga_sync_sampler
// Description : Input register stage for an incoming VGA stream plus the
//               hs/vs edge detector working on the registered values.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_sampler
    import vga_timing_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_hs,
    input  logic             i_vs,
    input  logic [RGB_W-1:0] i_rgb,
    output logic [RGB_W-1:0] o_rgb,
    output logic             o_hs_fall,
    output logic             o_hs_rise,
    output logic             o_vs_fall,
    output logic             o_vs_rise
);

    logic             r_hs;
    logic             r_vs;
    logic             r_hs_prev;
    logic             r_vs_prev;
    logic [RGB_W-1:0] r_rgb;

    // Stage-1 sample and one-deep history; syncs idle high so reset never
    // produces a false edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hs      <= 1'b1;
            r_vs      <= 1'b1;
            r_hs_prev <= 1'b1;
            r_vs_prev <= 1'b1;
            r_rgb     <= '0;
        end else begin
            r_hs      <= i_hs;
            r_vs      <= i_vs;
            r_hs_prev <= r_hs;
            r_vs_prev <= r_vs;
            r_rgb     <= i_rgb;
        end
    end

    assign o_rgb     = r_rgb;
    assign o_hs_fall =  r_hs_prev & ~r_hs;
    assign o_hs_rise = ~r_hs_prev &  r_hs;
    assign o_vs_fall =  r_vs_prev & ~r_vs;
    assign o_vs_rise = ~r_vs_prev &  r_vs;

endmodule : vga_sync_sampler
`default_nettype wire

// File: rtl/vga_sync_decoder.sv
`default_nettype none
// ============================================================================
// Module      : vga_sync_decoder
// Description : Receive-side VGA timing recovery. Rebuilds h/v counters from
//               the sync edges, checks every line and frame against the
//               timing table, tracks lock and emits per-pixel x/y/data.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_decoder
    import vga_timing_pkg::*;
#(
    parameter int H_SYNC_LEN  = H_SYNC,
    parameter int H_BACK_LEN  = H_BACK,
    parameter int H_DISP_LEN  = H_DISP,
    parameter int H_TOTAL_LEN = H_TOTAL,
    parameter int V_SYNC_LEN  = V_SYNC,
    parameter int V_BACK_LEN  = V_BACK,
    parameter int V_DISP_LEN  = V_DISP,
    parameter int V_TOTAL_LEN = V_TOTAL
) (
    input  logic                 vga_clk,
    input  logic                 sys_rst_n,
    input  logic                 vga_hs,
    input  logic                 vga_vs,
    input  logic [RGB_W-1:0]     vga_rgb,
    output logic [RGB_W-1:0]     pixel_data,
    output logic [CNT_W-1:0]     pixel_x,
    output logic [CNT_W-1:0]     pixel_y,
    output logic                 pixel_valid,
    output logic                 frame_start,
    output logic                 locked,
    output logic                 sync_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    // Counter landmarks
    localparam logic [CNT_W-1:0] c_H_TOTAL     = CNT_W'(H_TOTAL_LEN);
    localparam logic [CNT_W-1:0] c_H_LAST      = CNT_W'(H_TOTAL_LEN - 1);
    localparam logic [CNT_W-1:0] c_H_SYNC_LAST = CNT_W'(H_SYNC_LEN - 1);
    localparam logic [CNT_W-1:0] c_H_ACT_START = CNT_W'(H_SYNC_LEN + H_BACK_LEN);
    localparam logic [CNT_W-1:0] c_H_ACT_END   = CNT_W'(H_SYNC_LEN + H_BACK_LEN + H_DISP_LEN);
    localparam logic [CNT_W-1:0] c_V_TOTAL     = CNT_W'(V_TOTAL_LEN);
    localparam logic [CNT_W-1:0] c_V_LAST      = CNT_W'(V_TOTAL_LEN - 1);
    localparam logic [CNT_W-1:0] c_V_SYNC      = CNT_W'(V_SYNC_LEN);
    localparam logic [CNT_W-1:0] c_V_ACT_START = CNT_W'(V_SYNC_LEN + V_BACK_LEN);
    localparam logic [CNT_W-1:0] c_V_ACT_END   = CNT_W'(V_SYNC_LEN + V_BACK_LEN + V_DISP_LEN);
    localparam logic [ERR_CNT_W-1:0] c_ERR_MAX = '1;

    // Stage-1 outputs
    logic [RGB_W-1:0] w_rgb_s1;
    logic             w_hs_fall;
    logic             w_hs_rise;
    logic             w_vs_fall;
    logic             w_vs_rise;

    // Stage-2: counters aligned with the stage-2 colour
    logic [RGB_W-1:0] r_rgb_s2;
    logic [CNT_W-1:0] r_h_cnt;
    logic [CNT_W-1:0] r_v_cnt;
    logic [CNT_W-1:0] w_h_cnt_next;
    logic [CNT_W-1:0] w_v_cnt_next;

    // Checks and lock state
    logic        w_err_any;
    logic        w_err;
    logic        r_err_d1;
    sync_state_t r_state;
    sync_state_t w_state_next;

    // Output stage
    logic                 w_in_window;
    logic                 w_valid_next;
    logic [RGB_W-1:0]     r_pixel_data;
    logic [CNT_W-1:0]     r_pixel_x;
    logic [CNT_W-1:0]     r_pixel_y;
    logic                 r_pixel_valid;
    logic                 r_frame_start;
    logic                 r_locked;
    logic                 r_sync_err;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    vga_sync_sampler u_sampler (
        .clk       (vga_clk),
        .rst       (sys_rst_n),
        .i_hs      (vga_hs),
        .i_vs      (vga_vs),
        .i_rgb     (vga_rgb),
        .o_rgb     (w_rgb_s1),
        .o_hs_fall (w_hs_fall),
        .o_hs_rise (w_hs_rise),
        .o_vs_fall (w_vs_fall),
        .o_vs_rise (w_vs_rise)
    );

    // Next counter values: h restarts on every hs fall, v on hs fall with vs fall;
    // both hold once they reach their total so a dead link cannot wrap.
    always_comb begin
        w_h_cnt_next = r_h_cnt;
        w_v_cnt_next = r_v_cnt;
        if (w_hs_fall) begin
            w_h_cnt_next = '0;
        end else if (r_h_cnt != c_H_TOTAL) begin
            w_h_cnt_next = r_h_cnt + 10'd1;
        end
        if (w_hs_fall) begin
            if (w_vs_fall) begin
                w_v_cnt_next = '0;
            end else if (r_v_cnt != c_V_TOTAL) begin
                w_v_cnt_next = r_v_cnt + 10'd1;
            end
        end
    end

    // Timing checks. r_h_cnt holds the count of the previous sample, so an
    // hs rise is correct when the last low sample was numbered H_SYNC-1 (the
    // rising sample itself becomes H_SYNC). Timeouts fire once, on arrival.
    always_comb begin
        w_err_any = 1'b0;
        if (w_hs_fall && (r_h_cnt != c_H_LAST))          w_err_any = 1'b1;
        if (w_hs_rise && (r_h_cnt != c_H_SYNC_LAST))     w_err_any = 1'b1;
        if (w_vs_fall && (r_v_cnt != c_V_LAST))          w_err_any = 1'b1;
        if (w_vs_rise && (w_v_cnt_next != c_V_SYNC))     w_err_any = 1'b1;
        if ((w_h_cnt_next == c_H_TOTAL) && (r_h_cnt != c_H_TOTAL)) w_err_any = 1'b1;
        if ((w_v_cnt_next == c_V_TOTAL) && (r_v_cnt != c_V_TOTAL)) w_err_any = 1'b1;
        w_err = w_err_any && (r_state != SEARCH);
    end

    // Lock FSM next state; an error always wins over a simultaneous vs fall.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            SEARCH:  if (w_vs_fall) w_state_next = VERIFY;
            VERIFY: begin
                if (w_err)          w_state_next = SEARCH;
                else if (w_vs_fall) w_state_next = LOCKED;
            end
            LOCKED:  if (w_err)     w_state_next = SEARCH;
            default:                w_state_next = SEARCH;
        endcase
    end

    // Stage-2 registers: counters, colour, lock state and the error delay.
    always_ff @(posedge vga_clk or posedge sys_rst_n) begin
        if (sys_rst_n) begin
            r_h_cnt  <= '0;
            r_v_cnt  <= '0;
            r_rgb_s2 <= '0;
            r_state  <= SEARCH;
            r_err_d1 <= 1'b0;
        end else begin
            r_h_cnt  <= w_h_cnt_next;
            r_v_cnt  <= w_v_cnt_next;
            r_rgb_s2 <= w_rgb_s1;
            r_state  <= w_state_next;
            r_err_d1 <= w_err;
        end
    end

    assign w_in_window  = (r_h_cnt >= c_H_ACT_START) && (r_h_cnt < c_H_ACT_END) &&
                          (r_v_cnt >= c_V_ACT_START) && (r_v_cnt < c_V_ACT_END);
    assign w_valid_next = (r_state == LOCKED) && w_in_window;

    // Registered outputs; coordinates and data are forced to 0 off the window.
    always_ff @(posedge vga_clk or posedge sys_rst_n) begin
        if (sys_rst_n) begin
            r_pixel_data  <= '0;
            r_pixel_x     <= '0;
            r_pixel_y     <= '0;
            r_pixel_valid <= 1'b0;
            r_frame_start <= 1'b0;
            r_locked      <= 1'b0;
            r_sync_err    <= 1'b0;
            r_err_cnt     <= '0;
        end else begin
            r_pixel_valid <= w_valid_next;
            r_pixel_data  <= w_valid_next ? r_rgb_s2 : '0;
            r_pixel_x     <= w_valid_next ? (r_h_cnt - c_H_ACT_START) : '0;
            r_pixel_y     <= w_valid_next ? (r_v_cnt - c_V_ACT_START) : '0;
            r_frame_start <= w_valid_next && (r_h_cnt == c_H_ACT_START) &&
                             (r_v_cnt == c_V_ACT_START);
            r_locked      <= (r_state == LOCKED);
            r_sync_err    <= r_err_d1;
            if (r_err_d1 && (r_err_cnt != c_ERR_MAX)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign pixel_data  = r_pixel_data;
    assign pixel_x     = r_pixel_x;
    assign pixel_y     = r_pixel_y;
    assign pixel_valid = r_pixel_valid;
    assign frame_start = r_frame_start;
    assign locked      = r_locked;
    assign sync_err    = r_sync_err;
    assign err_cnt     = r_err_cnt;

endmodule : vga_sync_decoder
`default_nettype wire

// File: tb/tb_vga_sync_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_sync_decoder
// Description : Directed self-checking bench for vga_sync_decoder on a
//               reduced timing geometry (20 clocks x 12 lines per frame).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_sync_decoder;

    localparam int HS = 4;
    localparam int HB = 3;
    localparam int HD = 8;
    localparam int HT = 20;
    localparam int VS = 2;
    localparam int VB = 3;
    localparam int VD = 4;
    localparam int VT = 12;

    logic        vga_clk = 1'b0;
    logic        sys_rst_n;
    logic        vga_hs;
    logic        vga_vs;
    logic [11:0] vga_rgb;
    logic [11:0] pixel_data;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        pixel_valid;
    logic        frame_start;
    logic        locked;
    logic        sync_err;
    logic [7:0]  err_cnt;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;
    int lock_rise_edge = -1;
    int lock_fall_edge = -1;
    int err_edge = -1;
    int err_pulses = 0;
    int valid_cnt = 0;
    int fs_cnt = 0;
    int k = 0;
    int mod_edge = 0;
    bit mon_en = 1'b0;
    logic prev_locked = 1'b0;
    logic [9:0] last_x = '0;
    logic [9:0] last_y = '0;

    vga_sync_decoder #(
        .H_SYNC_LEN (HS), .H_BACK_LEN (HB), .H_DISP_LEN (HD), .H_TOTAL_LEN (HT),
        .V_SYNC_LEN (VS), .V_BACK_LEN (VB), .V_DISP_LEN (VD), .V_TOTAL_LEN (VT)
    ) dut (
        .vga_clk     (vga_clk),
        .sys_rst_n   (sys_rst_n),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .vga_rgb     (vga_rgb),
        .pixel_data  (pixel_data),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .pixel_valid (pixel_valid),
        .frame_start (frame_start),
        .locked      (locked),
        .sync_err    (sync_err),
        .err_cnt     (err_cnt)
    );

    always #5 vga_clk = ~vga_clk;

    always @(posedge vga_clk) edge_cnt <= edge_cnt + 1;

    // Observe outputs mid-cycle: lock/error event times and raster order.
    always @(negedge vga_clk) begin
        logic [9:0]  xv;
        logic [9:0]  yv;
        logic [11:0] dv;
        if (locked && !prev_locked) lock_rise_edge = edge_cnt;
        if (!locked && prev_locked) lock_fall_edge = edge_cnt;
        prev_locked = locked;
        if (sync_err) begin
            err_edge   = edge_cnt;
            err_pulses = err_pulses + 1;
        end
        if (frame_start) fs_cnt = fs_cnt + 1;
        if (pixel_valid) begin
            if (mon_en) begin
                xv = 10'(k % HD);
                yv = 10'(k / HD);
                dv = {xv[3:0], yv[3:0], xv[7:4]};
                checks = checks + 1;
                assert (pixel_x === xv && pixel_y === yv && pixel_data === dv &&
                        frame_start === (k == 0))
                else begin
                    errors = errors + 1;
                    $error("FAIL pixel k=%0d: got x=%0d y=%0d d=%h fs=%b expected x=%0d y=%0d d=%h fs=%b",
                           k, pixel_x, pixel_y, pixel_data, frame_start, xv, yv, dv, (k == 0));
                end
                k = k + 1;
            end
            valid_cnt = valid_cnt + 1;
            last_x    = pixel_x;
            last_y    = pixel_y;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        assert (got === exp)
        else begin
            errors = errors + 1;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present one sample; returns 1 ns after the edge that captured it.
    task automatic drive_clk(input logic hs, input logic vs, input logic [11:0] rgb);
        vga_hs  = hs;
        vga_vs  = vs;
        vga_rgb = rgb;
        @(posedge vga_clk);
        #1;
    endtask

    // One line; rst_col >= 0 pulses reset for 3 clocks starting at that column.
    task automatic drive_line(input int line, input int len, input int hsw,
                              input logic vs_lvl, input int rst_col);
        logic [9:0]  xv;
        logic [9:0]  yv;
        logic [11:0] rgb;
        for (int c = 0; c < len; c++) begin
            xv = 10'(c - (HS + HB));
            yv = 10'(line - (VS + VB));
            if (c >= HS + HB && c < HS + HB + HD && line >= VS + VB && line < VS + VB + VD)
                rgb = {xv[3:0], yv[3:0], xv[7:4]};
            else
                rgb = 12'h000;
            if (c == rst_col) begin
                chk("pre_rst_valid", pixel_valid, 1);
                chk("pre_rst_x", pixel_x, 0);
                chk("pre_rst_y", pixel_y, 1);
                chk("pre_rst_data", pixel_data, 12'h010);
                chk("pre_rst_err_cnt", err_cnt, 3);
                sys_rst_n = 1'b1;
                #1;
                chk("rst_mid_data", pixel_data, 0);
                chk("rst_mid_x", pixel_x, 0);
                chk("rst_mid_y", pixel_y, 0);
                chk("rst_mid_valid", pixel_valid, 0);
                chk("rst_mid_fs", frame_start, 0);
                chk("rst_mid_locked", locked, 0);
                chk("rst_mid_sync_err", sync_err, 0);
                chk("rst_mid_err_cnt", err_cnt, 0);
            end
            if (rst_col >= 0 && c == rst_col + 3) sys_rst_n = 1'b0;
            drive_clk((c < hsw) ? 1'b0 : 1'b1, vs_lvl, rgb);
        end
    endtask

    task automatic drive_frame(input int mod_line, input int mod_len, input int mod_hs,
                               input int rst_line);
        int len;
        int hsw;
        for (int l = 0; l < VT; l++) begin
            len = HT;
            hsw = HS;
            if (l == mod_line) begin
                len      = mod_len;
                hsw      = mod_hs;
                mod_edge = edge_cnt;
            end
            drive_line(l, len, hsw, (l < VS) ? 1'b0 : 1'b1, (l == rst_line) ? 10 : -1);
        end
    endtask

    initial begin
        int t;
        int p;
        int r;
        sys_rst_n = 1'b1;
        vga_hs    = 1'b1;
        vga_vs    = 1'b1;
        vga_rgb   = 12'h000;
        repeat (3) drive_clk(1'b1, 1'b1, 12'h000);
        chk("rst_data", pixel_data, 0);
        chk("rst_x", pixel_x, 0);
        chk("rst_y", pixel_y, 0);
        chk("rst_valid", pixel_valid, 0);
        chk("rst_fs", frame_start, 0);
        chk("rst_locked", locked, 0);
        chk("rst_sync_err", sync_err, 0);
        chk("rst_err_cnt", err_cnt, 0);
        sys_rst_n = 1'b0;
        repeat (5) drive_clk(1'b1, 1'b1, 12'h000);

        // Frame 1: first vs fall enters VERIFY, no lock yet
        drive_frame(-1, HT, HS, -1);
        chk("f1_unlocked", locked, 0);

        // Frame 2: lock 2 cycles after the second vs fall, raster checked
        t = edge_cnt; valid_cnt = 0; fs_cnt = 0; k = 0; mon_en = 1'b1;
        drive_frame(-1, HT, HS, -1);
        chk("lock_rise_edge", lock_rise_edge, t + 3);
        chk("f2_valid_cnt", valid_cnt, HD * VD);
        chk("f2_fs_cnt", fs_cnt, 1);
        chk("f2_last_x", last_x, HD - 1);
        chk("f2_last_y", last_y, VD - 1);

        // Frame 3: still locked, clean
        valid_cnt = 0; fs_cnt = 0; k = 0;
        drive_frame(-1, HT, HS, -1);
        mon_en = 1'b0;
        chk("f3_valid_cnt", valid_cnt, HD * VD);
        chk("f3_locked", locked, 1);
        chk("f3_err_cnt", err_cnt, 0);
        chk("f3_err_pulses", err_pulses, 0);

        // Frame 4: one line one clock too long while locked
        p = err_pulses;
        drive_frame(6, HT + 1, HS, -1);
        chk("long_err_edge", err_edge, mod_edge + HT + 3);
        chk("long_lock_fall_edge", lock_fall_edge, mod_edge + HT + 3);
        chk("long_err_cnt", err_cnt, 1);
        chk("long_err_pulses", err_pulses - p, 1);
        chk("long_locked", locked, 0);

        // Frames 5/6: relock after one clean verified frame
        drive_frame(-1, HT, HS, -1);
        chk("f5_unlocked", locked, 0);
        t = edge_cnt;
        drive_frame(-1, HT, HS, -1);
        chk("relock_edge", lock_rise_edge, t + 3);

        // vs stuck high: vertical timeout on the first line past the frame
        t = edge_cnt; p = err_pulses;
        repeat (20) drive_line(VT, HT, HS, 1'b1, -1);
        chk("stuck_err_edge", err_edge, t + 3);
        chk("stuck_err_cnt", err_cnt, 2);
        chk("stuck_err_pulses", err_pulses - p, 1);
        chk("stuck_locked", locked, 0);

        // Frame 7: enters VERIFY, then an hs pulse one clock short
        p = err_pulses;
        drive_frame(3, HT, HS - 1, -1);
        chk("short_err_edge", err_edge, mod_edge + HS + 2);
        chk("short_err_cnt", err_cnt, 3);
        chk("short_err_pulses", err_pulses - p, 1);
        chk("short_locked", locked, 0);

        // Frame 8: its vs fall only re-enters VERIFY
        r = lock_rise_edge;
        drive_frame(-1, HT, HS, -1);
        chk("f8_unlocked", locked, 0);
        chk("f8_no_rise", lock_rise_edge, r);

        // Frame 9: locks at its start, then async reset mid active line
        t = edge_cnt;
        drive_frame(-1, HT, HS, 6);
        chk("f9_lock_edge", lock_rise_edge, t + 3);
        chk("post_rst_locked", locked, 0);
        chk("post_rst_err_cnt", err_cnt, 0);

        // Frames 10/11: a full verified frame is needed again
        drive_frame(-1, HT, HS, -1);
        chk("f10_unlocked", locked, 0);
        t = edge_cnt;
        drive_frame(-1, HT, HS, -1);
        chk("f11_lock_edge", lock_rise_edge, t + 3);
        chk("f11_err_cnt", err_cnt, 0);

        repeat (3) drive_clk(1'b1, 1'b1, 12'h000);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_vga_sync_decoder
`default_nettype wire

// File: doc/vga_sync_decoder.md
# vga_sync_decoder

Receive-side counterpart of the VGA timing driver. It samples an incoming 640x480@60 VGA stream (active-low hs/vs, 12-bit RGB 4:4:4) on the pixel clock and rebuilds the horizontal and vertical counters from the sync edges. It checks every line and frame against the fixed timing table, reports lock and sync errors, and emits per-pixel coordinates and data. It sits between a VGA capture input (or a loopback of the driver output) and downstream pixel consumers such as a frame buffer writer or checksum unit.

## Interface
- H_SYNC, 96, hs low width in clocks
- H_BACK, 48, horizontal back porch
- H_DISP, 640, active pixels per line
- H_TOTAL, 800, clocks per line
- V_SYNC, 2, vs low width in lines
- V_BACK, 33, vertical back porch
- V_DISP, 480, active lines
- V_TOTAL, 525, lines per frame
- vga_clk  in  1  pixel clock (25 MHz nominal)
- sys_rst_n  in  1  reset; asynchronous, active-high (despite the name)
- vga_hs  in  1  horizontal sync, active low
- vga_vs  in  1  vertical sync, active low, changes coincident with hs falling edge
- vga_rgb  in  12  pixel colour {R[3:0],G[3:0],B[3:0]}
- pixel_data  out  12  registered colour of the current active pixel, 0 when not valid
- pixel_x  out  10  active column 0..639, 0 when not valid
- pixel_y  out  10  active row 0..479, 0 when not valid
- pixel_valid  out  1  high for each active pixel while locked
- frame_start  out  1  one-cycle pulse coincident with pixel (0,0)
- locked  out  1  timing verified
- sync_err  out  1  one-cycle pulse per detected timing violation
- err_cnt  out  8  saturating count of sync_err pulses

## Operation
- Stage 1: register vga_hs/vga_vs/vga_rgb. On reset, the hs/vs registers reset to 1 and the previous-value registers reset to 1, so no spurious edge occurs.
- Edge detection on the stage-1 values gives hs_fall, hs_rise, vs_fall, vs_rise.
- h_cnt (10 b):
  - 0 on hs_fall, otherwise +1.
  - Saturates at H_TOTAL; reaching H_TOTAL is a timeout error.
- v_cnt (10 b):
  - 0 on hs_fall with vs_fall, +1 on any other hs_fall.
  - Reaching V_TOTAL is a timeout error.
- Checks, all evaluated only outside SEARCH:
  - hs_fall: h_cnt must equal H_TOTAL-1.
  - hs_rise: h_cnt must equal H_SYNC.
  - vs_fall: v_cnt must equal V_TOTAL-1.
  - vs_rise: the next v_cnt must equal V_SYNC.
  - Plus both timeouts.
- FSM (states in the shared package):
  - SEARCH: counters free-run; vs_fall -> VERIFY.
  - VERIFY: any error -> SEARCH; vs_fall with no error since entry -> LOCKED.
  - LOCKED: any error -> SEARCH.
  - An error in VERIFY or LOCKED pulses sync_err and increments err_cnt, saturating at 255.
- Active window: h_cnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_DISP) and v_cnt in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_DISP).
- Active-pixel outputs:
  - pixel_valid = locked and in the active window.
  - pixel_x = h_cnt-144 and pixel_y = v_cnt-35, in 10-bit unsigned arithmetic, computed only inside the window.
- Simultaneous error and vs_fall in VERIFY: the error wins and the state goes to SEARCH.
- Reset mid-frame: all state is cleared immediately, state = SEARCH, and err_cnt = 0.

## Timing
- All outputs are registered. Reset values: pixel_data=0, pixel_x=0, pixel_y=0, pixel_valid=0, frame_start=0, locked=0, sync_err=0, err_cnt=0.
- Latency: a vga_rgb sample at input edge n appears on pixel_data after edge n+2, together with its x/y/valid.
- locked rises 2 cycles after the second clean vs falling edge, i.e. one full verified frame (420000 clocks) after the first.
- locked falls, and sync_err pulses, 2 cycles after the violating input sample.
- pixel_valid drops in the same cycle that locked falls.
- No backpressure: downstream must accept one pixel per clock.

## Structure
- Shared package vga_timing_pkg:
  - Timing constants (H_/V_ values above, also reused by vga_driver).
  - Colour localparams.
  - The FSM state enum {SEARCH, VERIFY, LOCKED}.
- One sub-module, vga_sync_sampler: the input register stage plus the hs/vs edge detector. The counters, checks, FSM and output stage live in the top.

## Test plan
- Clean driver-timed frames after reset -> locked=1 at 2 cycles past the 2nd vs fall; err_cnt stays 0 over 3 frames.
- Pattern rgb={x[3:0],y[3:0],x[7:4]} with locked=1:
  - First valid output has x=0, y=0, data=12'h000 and frame_start=1.
  - Last valid output has x=639, y=479.
  - Exactly 307200 valid cycles per frame.
- One 801-clock line while locked -> sync_err pulse, locked=0, err_cnt=1; relock after one further clean frame.
- hs low width 95 clocks in VERIFY -> sync_err, return to SEARCH, no lock at the next vs fall.
- vs held high for 600 lines -> timeout error at v_cnt=525; locked=0, err_cnt increments once.
- Async reset asserted mid-line in LOCKED -> all outputs 0 with no clock edge; after release, lock is regained only after a full verified frame.
